// File: rtl/apg_run_sequencer_if.sv
// Sequencer bus: run control/status, sample-memory read port and capture-memory write port.
// master = config registers + memories side, slave = apg_run_sequencer.
interface apg_run_sequencer_if #(
    parameter  int NUM_SIG  = 14,
    parameter  int NUM_SAMP = 128,
    parameter  int LOOP_W   = 16,
    localparam int ADDR_W   = $clog2(NUM_SAMP)
);
    logic                start;
    logic                abort;
    logic [ADDR_W:0]     cfg_n_samp;
    logic [LOOP_W-1:0]   cfg_loops;
    logic                busy;
    logic                done;
    logic                aborted;
    logic                err;
    logic [LOOP_W-1:0]   loop_count;
    logic                mem_rd_en;
    logic [ADDR_W-1:0]   mem_rd_addr;
    logic [NUM_SIG-1:0]  mem_rd_data;
    logic [NUM_SIG-1:0]  output_signals;
    logic [NUM_SIG-1:0]  input_signals;
    logic                cap_we;
    logic [ADDR_W-1:0]   cap_addr;
    logic [NUM_SIG-1:0]  cap_data;

    modport master (
        output start, abort, cfg_n_samp, cfg_loops, mem_rd_data, input_signals,
        input  busy, done, aborted, err, loop_count, mem_rd_en, mem_rd_addr,
               output_signals, cap_we, cap_addr, cap_data
    );

    modport slave (
        input  start, abort, cfg_n_samp, cfg_loops, mem_rd_data, input_signals,
        output busy, done, aborted, err, loop_count, mem_rd_en, mem_rd_addr,
               output_signals, cap_we, cap_addr, cap_data
    );
endinterface

// File: rtl/apg_run_sequencer.sv
// Pattern sequencer: plays sample memory to output_signals n*loops times, then drains.
// APG_SEQ_CAPTURE_EN adds a capture write of input_signals for every displayed sample.
module apg_run_sequencer #(
    parameter  int NUM_SIG  = 14,
    parameter  int NUM_SAMP = 128,
    parameter  int LOOP_W   = 16,
    localparam int ADDR_W   = $clog2(NUM_SAMP)
) (
    input logic                wave_clk,
    input logic                wave_reset,
    apg_run_sequencer_if.slave bus
);
`ifdef APG_SEQ_CAPTURE_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 1;
`endif
    localparam logic [ADDR_W:0]   ONE_N   = 1;
    localparam logic [ADDR_W-1:0] ONE_A   = 1;
    localparam logic [LOOP_W-1:0] ONE_L   = 1;
    localparam logic [ADDR_W:0]   MAX_N   = (ADDR_W+1)'(NUM_SAMP);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W:0]     n_lat;
    logic [LOOP_W-1:0]   loops_lat, loop_count;
    logic [ADDR_W-1:0]   rd_addr;
    logic                drain_cnt, done_q, aborted_q, err_q;
    logic [STAGES:0]     vld_pipe;
    logic [NUM_SIG-1:0]  out_q;
    logic                busy, kill, cfg_ok, accept, last_addr, last_loop;

    assign busy      = (state != IDLE);
    assign kill      = busy && bus.abort;
    assign cfg_ok    = (bus.cfg_n_samp != '0) && (bus.cfg_n_samp <= MAX_N);
    assign accept    = (state == IDLE) && bus.start && !bus.abort && cfg_ok;
    assign last_addr = ({1'b0, rd_addr} == n_lat - ONE_N);
    assign last_loop = (loops_lat != '0) && (loop_count + ONE_L == loops_lat);

    always_ff @(posedge wave_clk) begin
        if (wave_reset) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (bus.abort) state_nxt = IDLE;
                     else if (last_addr && last_loop) state_nxt = DRAIN;
            DRAIN:   if (bus.abort || drain_cnt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // vld_pipe[0]: read issued, [1]: read data present, [2]: sample on output
    always_ff @(posedge wave_clk) begin
        if (wave_reset) begin
            n_lat      <= '0;
            loops_lat  <= '0;
            loop_count <= '0;
            rd_addr    <= '0;
            drain_cnt  <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            err_q      <= 1'b0;
            vld_pipe   <= '0;
            out_q      <= '0;
        end else begin
            done_q    <= (state == DRAIN) && drain_cnt && !bus.abort;
            drain_cnt <= (state == DRAIN) && !drain_cnt && !bus.abort;
            if (accept) begin
                n_lat      <= bus.cfg_n_samp;
                loops_lat  <= bus.cfg_loops;
                loop_count <= '0;
                rd_addr    <= '0;
                aborted_q  <= 1'b0;
                err_q      <= 1'b0;
            end else if (state == IDLE && bus.start && !bus.abort) begin
                err_q <= 1'b1;
            end
            if (kill) aborted_q <= 1'b1;
            if (state == RUN && !bus.abort) begin
                rd_addr <= last_addr ? '0 : rd_addr + ONE_A;
                if (last_addr) loop_count <= loop_count + ONE_L;
            end
            if (kill) vld_pipe <= '0;
            else      vld_pipe <= {vld_pipe[STAGES-1:0], state_nxt == RUN};
            if (vld_pipe[1] && !kill) out_q <= bus.mem_rd_data;
        end
    end

    assign bus.busy           = busy;
    assign bus.done           = done_q;
    assign bus.aborted        = aborted_q;
    assign bus.err            = err_q;
    assign bus.loop_count     = loop_count;
    assign bus.mem_rd_en      = (state == RUN);
    assign bus.mem_rd_addr    = rd_addr;
    assign bus.output_signals = out_q;

`ifdef APG_SEQ_CAPTURE_EN
    logic [ADDR_W-1:0]  addr_d1, addr_d2, cap_addr_q;
    logic [NUM_SIG-1:0] cap_data_q;
    logic               cap_we_q;

    // address follows the sample through the read and output stages
    always_ff @(posedge wave_clk) begin
        if (wave_reset) begin
            addr_d1    <= '0;
            addr_d2    <= '0;
            cap_we_q   <= 1'b0;
            cap_addr_q <= '0;
            cap_data_q <= '0;
        end else begin
            addr_d1  <= rd_addr;
            addr_d2  <= addr_d1;
            cap_we_q <= vld_pipe[2] && !kill;
            if (vld_pipe[2] && !kill) begin
                cap_addr_q <= addr_d2;
                cap_data_q <= bus.input_signals;
            end
        end
    end

    assign bus.cap_we   = cap_we_q;
    assign bus.cap_addr = cap_addr_q;
    assign bus.cap_data = cap_data_q;
`else
    assign bus.cap_we   = 1'b0;
    assign bus.cap_addr = '0;
    assign bus.cap_data = '0;
`endif
endmodule

// File: tb/tb_apg_run_sequencer.sv
// Scoreboard bench for apg_run_sequencer: runs push expected reads/samples/captures/done
// into queues at start time; a negedge monitor pops and compares as the DUT produces them.
module tb_apg_run_sequencer;
    localparam int NUM_SIG  = 14;
    localparam int NUM_SAMP = 128;
    localparam int LOOP_W   = 16;
    localparam int ADDR_W   = $clog2(NUM_SAMP);

    typedef struct {
        int                 cyc;
        int                 addr;
        logic [NUM_SIG-1:0] data;
    } exp_t;

    logic wave_clk   = 1'b0;
    logic wave_reset = 1'b1;
    int   cyc        = 0;
    int   checks     = 0;
    int   failures   = 0;
    bit   mon_en     = 1'b0;
    bit   m_aborted  = 1'b0;
    bit   m_err      = 1'b0;

    logic [NUM_SIG-1:0] mem [NUM_SAMP];
    exp_t exp_rd[$], exp_out[$], exp_cap[$], exp_done[$];

    apg_run_sequencer_if #(.NUM_SIG(NUM_SIG), .NUM_SAMP(NUM_SAMP), .LOOP_W(LOOP_W)) bus ();

    apg_run_sequencer #(.NUM_SIG(NUM_SIG), .NUM_SAMP(NUM_SAMP), .LOOP_W(LOOP_W)) dut (
        .wave_clk   (wave_clk),
        .wave_reset (wave_reset),
        .bus        (bus)
    );

    always #5 wave_clk = ~wave_clk;
    always @(posedge wave_clk) cyc <= cyc + 1;

    // sample memory: registered read, data valid the cycle after mem_rd_en
    always @(posedge wave_clk) if (bus.mem_rd_en === 1'b1) bus.mem_rd_data <= mem[bus.mem_rd_addr];
    assign bus.input_signals = bus.output_signals;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge wave_clk) if (mon_en) begin
        exp_t e;
        if (bus.mem_rd_en !== 1'b0) begin
            if (exp_rd.size() == 0) chk("rd_unexpected", bus.mem_rd_en, 0);
            else begin
                e = exp_rd.pop_front();
                chk("rd_cycle", cyc, e.cyc);
                chk("rd_addr", bus.mem_rd_addr, e.addr);
            end
        end
        if (exp_out.size() > 0 && exp_out[0].cyc == cyc) begin
            e = exp_out.pop_front();
            chk("out_data", bus.output_signals, e.data);
        end
        if (bus.done !== 1'b0) begin
            if (exp_done.size() == 0) chk("done_unexpected", bus.done, 0);
            else begin
                e = exp_done.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("done_loop_count", bus.loop_count, e.addr);
                chk("done_busy", bus.busy, 0);
            end
        end
`ifdef APG_SEQ_CAPTURE_EN
        if (bus.cap_we !== 1'b0) begin
            if (exp_cap.size() == 0) chk("cap_unexpected", bus.cap_we, 0);
            else begin
                e = exp_cap.pop_front();
                chk("cap_cycle", cyc, e.cyc);
                chk("cap_addr", bus.cap_addr, e.addr);
                chk("cap_data", bus.cap_data, e.data);
            end
        end
`else
        chk("cap_we_off", bus.cap_we, 0);
`endif
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_aborted"}, bus.aborted, 0);
        chk({tag, "_err"}, bus.err, 0);
        chk({tag, "_rd_en"}, bus.mem_rd_en, 0);
        chk({tag, "_rd_addr"}, bus.mem_rd_addr, 0);
        chk({tag, "_loop_count"}, bus.loop_count, 0);
        chk({tag, "_output"}, bus.output_signals, 0);
        chk({tag, "_cap_we"}, bus.cap_we, 0);
        chk({tag, "_cap_addr"}, bus.cap_addr, 0);
        chk({tag, "_cap_data"}, bus.cap_data, 0);
    endtask

    // One run. cut>0: abort (or reset if cut_rst) held in cycle start+cut.
    // mid>0: a second start with random cfg in cycle start+mid.
    task automatic run(input int n, input int loops, input int cut, input bit cut_rst, input int mid);
        int   s, a, total, last;
        exp_t e;
        for (int i = 0; i < NUM_SAMP; i++) mem[i] = NUM_SIG'($urandom);
        s     = cyc;
        a     = (cut > 0) ? s + cut : 0;
        total = (loops == 0) ? cut : n * loops;
        for (int i = 0; i < total; i++) begin
            if (a == 0 || s + 1 + i <= a) begin e = '{s + 1 + i, i % n, '0}; exp_rd.push_back(e); end
            if (a == 0 || s + 3 + i <= a) begin e = '{s + 3 + i, i % n, mem[i % n]}; exp_out.push_back(e); end
`ifdef APG_SEQ_CAPTURE_EN
            if (a == 0 || s + 4 + i <= a) begin e = '{s + 4 + i, i % n, mem[i % n]}; exp_cap.push_back(e); end
`endif
        end
        if (a == 0) begin e = '{s + total + 3, loops, '0}; exp_done.push_back(e); end
        bus.start      = 1'b1;
        bus.abort      = 1'b0;
        bus.cfg_n_samp = (ADDR_W+1)'(n);
        bus.cfg_loops  = LOOP_W'(loops);
        @(posedge wave_clk); #1;
        bus.start      = 1'b0;
        bus.cfg_n_samp = (ADDR_W+1)'($urandom);
        bus.cfg_loops  = LOOP_W'($urandom);
        m_aborted = 1'b0;
        m_err     = 1'b0;
        chk("start_busy", bus.busy, 1);
        chk("start_err_clr", bus.err, 0);
        chk("start_aborted_clr", bus.aborted, 0);
        while (cyc < ((a != 0) ? a : s + total + 5)) begin
            bus.start = (cyc == s + mid);
            if (bus.start) begin
                bus.cfg_n_samp = (ADDR_W+1)'($urandom);
                bus.cfg_loops  = LOOP_W'($urandom);
            end
            @(posedge wave_clk); #1;
        end
        bus.start = 1'b0;
        if (a != 0) begin
            if (cut_rst) wave_reset = 1'b1;
            else         bus.abort  = 1'b1;
            @(posedge wave_clk); #1;
            wave_reset = 1'b0;
            bus.abort  = 1'b0;
            if (cut_rst) begin
                m_aborted = 1'b0;
                chk_zero("midreset");
            end else begin
                m_aborted = 1'b1;
                chk("abort_busy", bus.busy, 0);
                chk("abort_flag", bus.aborted, 1);
                chk("abort_loop_count", bus.loop_count, (a - s - 1) / n);
                repeat (4) begin @(posedge wave_clk); #1; end
                last = a - s - 3;
                if (last >= 0) chk("abort_frozen", bus.output_signals, mem[last % n]);
            end
        end else begin
            chk("end_busy", bus.busy, 0);
            chk("end_err", bus.err, 0);
            chk("end_loop_count", bus.loop_count, loops);
            chk("end_hold", bus.output_signals, mem[(total - 1) % n]);
        end
    endtask

    task automatic bad_start(input int n);
        bus.start      = 1'b1;
        bus.cfg_n_samp = (ADDR_W+1)'(n);
        bus.cfg_loops  = 1;
        @(posedge wave_clk); #1;
        bus.start = 1'b0;
        m_err     = 1'b1;
        chk("bad_err", bus.err, 1);
        chk("bad_busy", bus.busy, 0);
        @(posedge wave_clk); #1;
        chk("bad_busy_hold", bus.busy, 0);
    endtask

    task automatic idle_start_abort();
        bus.start      = 1'b1;
        bus.abort      = 1'b1;
        bus.cfg_n_samp = 8;
        bus.cfg_loops  = 1;
        @(posedge wave_clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("sa_busy", bus.busy, 0);
        chk("sa_aborted", bus.aborted, m_aborted);
        chk("sa_err", bus.err, m_err);
        @(posedge wave_clk); #1;
        chk("sa_busy_hold", bus.busy, 0);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.cfg_n_samp = '0;
        bus.cfg_loops  = '0;
        repeat (3) @(posedge wave_clk);
        #1;
        chk_zero("reset");
        wave_reset = 1'b0;
        mon_en     = 1'b1;
        @(posedge wave_clk); #1;

        run(4, 2, 0, 1'b0, 0);
        run(1, 3, 0, 1'b0, 0);
        bad_start(0);
        bad_start(NUM_SAMP + 1);
        run(5, 1, 0, 1'b0, 0);
        run(NUM_SAMP, 0, 300, 1'b0, 0);
        idle_start_abort();
        run(16, 2, 0, 1'b0, 7);
        repeat (6) run($urandom_range(1, NUM_SAMP), $urandom_range(1, 3), 0, 1'b0, $urandom_range(0, 20));
        run(8, 2, 0, 1'b0, 0);
        run(NUM_SAMP, 0, 40, 1'b1, 5);
        repeat (4) begin @(posedge wave_clk); #1; end
        mon_en = 1'b0;

        chk("rd_queue_left", exp_rd.size(), 0);
        chk("out_queue_left", exp_out.size(), 0);
        chk("cap_queue_left", exp_cap.size(), 0);
        chk("done_queue_left", exp_done.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
